// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed stereo FIR sequencer.
// Sample, coefficient and accumulator widths are fixed here and used by every file.
package fir_seq_pkg;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int ACC_W  = 40;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR_L  = 3'd1,
        ST_WR_R  = 3'd2,
        ST_MAC_L = 3'd3,
        ST_MAC_R = 3'd4,
        ST_OUT   = 3'd5,
        ST_FLUSH = 3'd6
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    function automatic logic [DATA_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
        logic [DATA_W-1:0] res;
        if (v > SAT_MAX) begin
            res = SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            res = SAT_MIN[DATA_W-1:0];
        end else begin
            res = v[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_mac.sv
// Shared multiply-accumulate: signed product, accumulator with clear/enable,
// arithmetic right shift and saturation to the sample range.
module fir_mac
    import fir_seq_pkg::*;
#(
    parameter int FRAC_BITS = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [COEF_W-1:0] i_coef,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_sat
);

    logic signed [COEF_W+DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]         w_prod_ext;
    logic signed [ACC_W-1:0]         w_shift;
    logic signed [ACC_W-1:0]         r_acc;

    assign w_prod     = $signed(i_coef) * $signed(i_data);
    assign w_prod_ext = {{(ACC_W-COEF_W-DATA_W){w_prod[COEF_W+DATA_W-1]}}, w_prod};
    assign w_shift    = r_acc >>> FRAC_BITS;
    assign o_sat      = sat_fn(w_shift);

    // Accumulator: clear has priority over accumulate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= {ACC_W{1'b0}};
        end else if (i_clr) begin
            r_acc <= {ACC_W{1'b0}};
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end else begin
            r_acc <= r_acc;
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Stereo FIR controller: one MAC shared by L and R over a circular delay-line RAM.
// Optional macro FIR_FLUSH_ON_RESET_EN zeroes the whole delay line after reset.
module fir_mac_sequencer
    import fir_seq_pkg::*;
#(
    parameter int NTAPS     = 32,
    parameter int FRAC_BITS = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sample_valid,
    input  logic [DATA_W-1:0]        in_l,
    input  logic [DATA_W-1:0]        in_r,
    output logic                     busy,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_l,
    output logic [DATA_W-1:0]        out_r,
    output logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     dl_we,
    output logic [$clog2(NTAPS):0]   dl_addr,
    output logic [DATA_W-1:0]        dl_wdata,
    input  logic [DATA_W-1:0]        dl_rdata,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int LW = $clog2(NTAPS);
    localparam int CW = LW + 1;
    localparam logic [CW-1:0] CNT_MAC_LAST   = CW'(NTAPS);
    localparam logic [CW-1:0] CNT_FLUSH_LAST = CW'(2*NTAPS-1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [LW-1:0]     r_head;
    logic [DATA_W-1:0] r_in_l;
    logic [DATA_W-1:0] r_in_r;
    logic [DATA_W-1:0] r_sat_l;
    logic [DATA_W-1:0] r_out_l;
    logic [DATA_W-1:0] r_out_r;
    logic              r_out_valid;
    logic              r_overrun;
    logic              r_busy;
    logic              r_dl_we;
    logic [CW-1:0]     r_dl_addr;
    logic [DATA_W-1:0] r_dl_wdata;
    logic [LW-1:0]     r_coef_addr;

    logic              w_accept;
    logic              w_dl_we_nxt;
    logic [CW-1:0]     w_dl_addr_nxt;
    logic [DATA_W-1:0] w_dl_wdata_nxt;
    logic [LW-1:0]     w_coef_addr_nxt;
    logic              w_in_mac;
    logic              w_mac_clr;
    logic              w_mac_en;
    logic [DATA_W-1:0] w_sat;
    logic              w_flush_pend;

`ifdef FIR_FLUSH_ON_RESET_EN
    logic r_flush_pend;

    // Request a single delay-line flush after every reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_pend <= 1'b1;
        end else if (r_state == ST_IDLE) begin
            r_flush_pend <= 1'b0;
        end else begin
            r_flush_pend <= r_flush_pend;
        end
    end

    assign w_flush_pend = r_flush_pend;
`else
    assign w_flush_pend = 1'b0;
`endif

    // Slot 0 of each MAC phase has no returning data: it clears, the rest accumulate.
    assign w_in_mac  = (r_state == ST_MAC_L) || (r_state == ST_MAC_R);
    assign w_mac_clr = w_in_mac && (r_cnt == {CW{1'b0}});
    assign w_mac_en  = w_in_mac && (r_cnt != {CW{1'b0}});

    fir_mac #(.FRAC_BITS(FRAC_BITS)) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_mac_clr),
        .i_en    (w_mac_en),
        .i_coef  (coef_data),
        .i_data  (dl_rdata),
        .o_sat   (w_sat)
    );

    // Next state, plus the memory-port values to register for the following cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_accept        = 1'b0;
        w_dl_we_nxt     = 1'b0;
        w_dl_addr_nxt   = {CW{1'b0}};
        w_dl_wdata_nxt  = {DATA_W{1'b0}};
        w_coef_addr_nxt = {LW{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_flush_pend) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = {CW{1'b0}};
                end else if (sample_valid) begin
                    w_state_nxt = ST_WR_L;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_L: w_state_nxt = ST_WR_R;
            ST_WR_R: begin
                w_state_nxt = ST_MAC_L;
                w_cnt_nxt   = {CW{1'b0}};
            end
            ST_MAC_L: begin
                if (r_cnt == CNT_MAC_LAST) begin
                    w_state_nxt = ST_MAC_R;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_MAC_R: begin
                if (r_cnt == CNT_MAC_LAST) begin
                    w_state_nxt = ST_OUT;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_OUT: w_state_nxt = ST_IDLE;
            ST_FLUSH: begin
                if (r_cnt == CNT_FLUSH_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase

        case (w_state_nxt)
            ST_WR_L: begin
                w_dl_we_nxt    = 1'b1;
                w_dl_addr_nxt  = {1'b0, r_head};
                w_dl_wdata_nxt = w_accept ? in_l : r_in_l;
            end
            ST_WR_R: begin
                w_dl_we_nxt    = 1'b1;
                w_dl_addr_nxt  = {1'b1, r_head};
                w_dl_wdata_nxt = r_in_r;
            end
            ST_MAC_L: begin
                w_coef_addr_nxt = w_cnt_nxt[LW-1:0];
                w_dl_addr_nxt   = {1'b0, r_head + w_cnt_nxt[LW-1:0]};
            end
            ST_MAC_R: begin
                w_coef_addr_nxt = w_cnt_nxt[LW-1:0];
                w_dl_addr_nxt   = {1'b1, r_head + w_cnt_nxt[LW-1:0]};
            end
            ST_FLUSH: begin
                w_dl_we_nxt   = 1'b1;
                w_dl_addr_nxt = w_cnt_nxt;
            end
            default: begin
                w_dl_we_nxt = 1'b0;
            end
        endcase
    end

    // FSM state, counter and registered memory-port outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_busy      <= 1'b0;
            r_dl_we     <= 1'b0;
            r_dl_addr   <= {CW{1'b0}};
            r_dl_wdata  <= {DATA_W{1'b0}};
            r_coef_addr <= {LW{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_dl_we     <= w_dl_we_nxt;
            r_dl_addr   <= w_dl_addr_nxt;
            r_dl_wdata  <= w_dl_wdata_nxt;
            r_coef_addr <= w_coef_addr_nxt;
        end
    end

    // Sample latch, L-result hold, output registers, head pointer and overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head      <= {LW{1'b0}};
            r_in_l      <= {DATA_W{1'b0}};
            r_in_r      <= {DATA_W{1'b0}};
            r_sat_l     <= {DATA_W{1'b0}};
            r_out_l     <= {DATA_W{1'b0}};
            r_out_r     <= {DATA_W{1'b0}};
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_in_l <= in_l;
                r_in_r <= in_r;
            end
            // The accumulator still holds the complete L sum during the first R slot.
            if ((r_state == ST_MAC_R) && w_mac_clr) begin
                r_sat_l <= w_sat;
            end
            if (r_state == ST_OUT) begin
                r_out_l <= r_sat_l;
                r_out_r <= w_sat;
                r_head  <= r_head - LW'(1);
            end
            r_out_valid <= (r_state == ST_OUT);
            if (sample_valid && ((r_state != ST_IDLE) || w_flush_pend)) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_l     = r_out_l;
    assign out_r     = r_out_r;
    assign coef_addr = r_coef_addr;
    assign dl_we     = r_dl_we;
    assign dl_addr   = r_dl_addr;
    assign dl_wdata  = r_dl_wdata;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomised bench for fir_mac_sequencer with ROM/RAM models and a
// convolution-sum reference built from per-channel sample histories.
module tb_fir_mac_sequencer;

    localparam int NTAPS = 32;
    localparam int LAT   = 2*NTAPS + 6;

    logic        clk;
    logic        reset_n;
    logic        sample_valid;
    logic        overrun_clr;
    logic [15:0] in_l;
    logic [15:0] in_r;
    logic        busy;
    logic        out_valid;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic [4:0]  coef_addr;
    logic [15:0] coef_data;
    logic        dl_we;
    logic [5:0]  dl_addr;
    logic [15:0] dl_wdata;
    logic [15:0] dl_rdata;
    logic        overrun;

    logic signed [15:0] rom [NTAPS];
    logic [15:0]        ram [2*NTAPS];
    logic               ram_clear;

    int n_checks;
    int n_pass;
    int hist_l[$];
    int hist_r[$];
    int head_m;

    fir_mac_sequencer #(.NTAPS(NTAPS), .FRAC_BITS(15)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .in_l         (in_l),
        .in_r         (in_r),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_l        (out_l),
        .out_r        (out_r),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .dl_we        (dl_we),
        .dl_addr      (dl_addr),
        .dl_wdata     (dl_wdata),
        .dl_rdata     (dl_rdata),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient ROM and delay-line RAM, both with one cycle of read latency.
    always @(posedge clk) begin
        coef_data <= rom[coef_addr];
        if (ram_clear) begin
            for (int i = 0; i < 2*NTAPS; i++) ram[i] <= 16'd0;
        end else if (dl_we) begin
            ram[dl_addr] <= dl_wdata;
        end
        dl_rdata <= ram[dl_addr];
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // y[n] = sat((sum_k h[k]*x[n-k]) >>> 15), x = 0 before the first sample.
    function automatic int model_y(input bit ch);
        longint s;
        int     xv;
        s = 0;
        for (int k = 0; k < NTAPS; k++) begin
            xv = 0;
            if (ch == 1'b0 && k < hist_l.size()) xv = hist_l[k];
            if (ch == 1'b1 && k < hist_r.size()) xv = hist_r[k];
            s += longint'(rom[k]) * longint'(xv);
        end
        s = s >>> 15;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    task automatic do_sample(input int l, input int r, input int inj, input bit inj_clr,
                             output int gl, output int gr);
        int errs;
        bit got;
        int el;
        int er;
        errs = 0; got = 1'b0; gl = 0; gr = 0;
        sample_valid = 1'b1; in_l = 16'(l); in_r = 16'(r);
        @(posedge clk); #1;
        sample_valid = 1'b0; in_l = 16'($urandom); in_r = 16'($urandom);
        hist_l.push_front(l); hist_r.push_front(r);
        if (hist_l.size() > NTAPS) void'(hist_l.pop_back());
        if (hist_r.size() > NTAPS) void'(hist_r.pop_back());
        el = model_y(1'b0);
        er = model_y(1'b1);
        for (int c = 1; c <= LAT + 10 && !got; c++) begin
            if (c == inj) begin
                sample_valid = 1'b1; overrun_clr = inj_clr;
            end
            if (inj > 0 && c == inj + 1) begin
                sample_valid = 1'b0; overrun_clr = 1'b0;
                check_val("overrun_set", longint'(overrun), 1);
            end
            if (busy !== (c < LAT)) errs++;
            if (dl_we !== (c == 1 || c == 2)) errs++;
            if (c == 1 && (dl_addr !== {1'b0, 5'(head_m)} || dl_wdata !== 16'(l))) errs++;
            if (c == 2 && (dl_addr !== {1'b1, 5'(head_m)} || dl_wdata !== 16'(r))) errs++;
            if (out_valid === 1'b1) begin
                got = 1'b1;
                if (c != LAT) errs++;
                gl = int'($signed(out_l));
                gr = int'($signed(out_r));
            end else begin
                @(posedge clk); #1;
            end
        end
        check_val("timing", errs, 0);
        check_val("out_valid_seen", longint'(got), 1);
        check_val("out_l", gl, el);
        check_val("out_r", gr, er);
        head_m = (head_m + NTAPS - 1) % NTAPS;
    endtask

    task automatic flush_check();
`ifdef FIR_FLUSH_ON_RESET_EN
        int nw;
        int errs;
        nw = 0; errs = 0;
        for (int c = 0; c < 4*NTAPS && !(nw == 2*NTAPS && busy === 1'b0); c++) begin
            if (dl_we === 1'b1) begin
                if (dl_addr !== 6'(nw) || dl_wdata !== 16'd0 || busy !== 1'b1) errs++;
                nw++;
            end
            @(posedge clk); #1;
        end
        check_val("flush_writes", nw, 2*NTAPS);
        check_val("flush_errs", errs, 0);
        check_val("flush_idle", longint'(busy), 0);
`else
        int nact;
        nact = 0;
        repeat (8) begin
            if (dl_we === 1'b1 || busy === 1'b1) nact++;
            @(posedge clk); #1;
        end
        check_val("noflush_idle", nact, 0);
`endif
    endtask

    initial begin
        int gl;
        int gr;
        int ov_cnt;
        n_checks = 0; n_pass = 0; head_m = 0;
        reset_n = 1'b0; sample_valid = 1'b0; overrun_clr = 1'b0;
        in_l = 16'd0; in_r = 16'd0; ram_clear = 1'b1;
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'sd0;
        repeat (3) @(posedge clk); #1;
        check_val("rst_busy", longint'(busy), 0);
        check_val("rst_out_valid", longint'(out_valid), 0);
        check_val("rst_overrun", longint'(overrun), 0);
        check_val("rst_dl_we", longint'(dl_we), 0);
        check_val("rst_dl_addr", longint'(dl_addr), 0);
        check_val("rst_coef_addr", longint'(coef_addr), 0);
        check_val("rst_out_l", longint'(out_l), 0);
        check_val("rst_out_r", longint'(out_r), 0);
        reset_n = 1'b1; ram_clear = 1'b0;
        flush_check();

        // Impulse: h[k] = k+1, one full-scale sample then zeros.
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'(k + 1);
        for (int i = 0; i <= NTAPS; i++) begin
            do_sample((i == 0) ? 32767 : 0, 0, 0, 1'b0, gl, gr);
            check_val("imp_l", gl, (i < NTAPS) ? i : 0);
            check_val("imp_r", gr, 0);
        end

        // Saturation at both rails with all coefficients at +0.99997.
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'sh7FFF;
        for (int i = 0; i < NTAPS; i++) do_sample(32767, 32767, 0, 1'b0, gl, gr);
        check_val("sat_pos", gl, 32767);
        for (int i = 0; i < NTAPS; i++) do_sample(-32768, -32768, 0, 1'b0, gl, gr);
        check_val("sat_neg", gr, -32768);

        // Overrun: extra strobe mid-computation, clear, then clear racing a set.
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'($urandom);
        check_val("overrun_idle", longint'(overrun), 0);
        do_sample(int'($signed(16'($urandom))), int'($signed(16'($urandom))), 10, 1'b0, gl, gr);
        overrun_clr = 1'b1; @(posedge clk); #1; overrun_clr = 1'b0;
        check_val("overrun_clr", longint'(overrun), 0);
        do_sample(int'($signed(16'($urandom))), int'($signed(16'($urandom))), 10, 1'b1, gl, gr);
        overrun_clr = 1'b1; @(posedge clk); #1; overrun_clr = 1'b0;

        // Ramp across the head wrap with random coefficients.
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'($urandom);
        for (int i = 0; i < 40; i++) do_sample(i, -i, 0, 1'b0, gl, gr);

        // Reset in the middle of a computation.
        sample_valid = 1'b1; in_l = 16'd12345; in_r = 16'd2222;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (19) @(posedge clk); #1;
        reset_n = 1'b0; #1;
        check_val("midrst_busy", longint'(busy), 0);
        check_val("midrst_out_valid", longint'(out_valid), 0);
        check_val("midrst_out_l", longint'(out_l), 0);
        check_val("midrst_out_r", longint'(out_r), 0);
        check_val("midrst_dl_we", longint'(dl_we), 0);
        ram_clear = 1'b1;
        repeat (3) @(posedge clk); #1;
        reset_n = 1'b1; ram_clear = 1'b0;
        hist_l.delete(); hist_r.delete(); head_m = 0;
        flush_check();
        ov_cnt = 0;
        repeat (LAT + 10) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) ov_cnt++;
        end
        check_val("no_out_valid_after_reset", ov_cnt, 0);
        for (int i = 0; i < 3; i++)
            do_sample(int'($signed(16'($urandom))), int'($signed(16'($urandom))), 0, 1'b0, gl, gr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed FIR engine controller for the channel-strip lowpass path. One internal multiply-accumulate is shared between left and right channels.
Per 48 kHz sample strobe it:
- writes both input samples into an external circular delay-line RAM,
- steps NTAPS coefficient/sample reads per channel,
- saturates and presents both outputs with a one-cycle valid.

Sits between the audio input deserialiser and the output stage. Coefficients come from an external ROM.

Parameters:
NTAPS, 32, filter length (power of 2, ≥4)
DATA_W, 16, sample width (signed)
COEF_W, 16, coefficient width (signed Q1.15)
ACC_W, 40, accumulator width
FRAC_BITS, 15, arithmetic right shift applied before saturation

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sample_valid  in  1  one-cycle strobe; in_l/in_r valid
in_l  in  DATA_W  left input sample
in_r  in  DATA_W  right input sample
busy  out  1  high whenever state ≠ IDLE
out_valid  out  1  one-cycle pulse; out_l/out_r updated
out_l  out  DATA_W  left filtered sample
out_r  out  DATA_W  right filtered sample
coef_addr  out  $clog2(NTAPS)  coefficient ROM address, 1-cycle read latency
coef_data  in  COEF_W  ROM read data
dl_we  out  1  delay-line write enable
dl_addr  out  $clog2(NTAPS)+1  {channel, index}; channel 0 = L, 1 = R
dl_wdata  out  DATA_W  delay-line write data
dl_rdata  in  DATA_W  delay-line read data, 1-cycle read latency
overrun  out  1  sticky: strobe arrived while busy
overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async, reset_n=0) puts every register in a known state:
  - state=IDLE, head=0, acc=0
  - out_l=out_r=0, out_valid=0, busy=0, overrun=0
  - dl_we=0, dl_addr=0, coef_addr=0
  - Reset mid-operation aborts the computation; no out_valid follows.
- States: IDLE → WR_L → WR_R → MAC_L → MAC_R → OUT → IDLE. Cycle numbering below uses c0 = the cycle sample_valid is sampled in IDLE.
- c0, IDLE: in_l/in_r latched.
- c1, WR_L: dl_we=1, dl_addr={0,head}, dl_wdata=latched in_l.
- c2, WR_R: same as WR_L with channel 1 and latched in_r.
- MAC_L occupies c3..c3+NTAPS (NTAPS+1 cycles):
  - Issue cycle k (k=0..NTAPS-1): coef_addr=k, dl_addr={0,(head+k) mod NTAPS}.
  - Data returns one cycle later; acc += sext(coef_data*dl_rdata).
  - acc is cleared on entry to MAC_L; the final cycle is drain only.
- MAC_R: same as MAC_L for channel 1; L result is held in a register meanwhile.
- OUT, c5+2·NTAPS:
  - out_l/out_r ← sat(acc >>> FRAC_BITS) to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - head ← (head-1) mod NTAPS, wrapping from 0 to NTAPS-1.
- out_valid is high for exactly one cycle at c6+2·NTAPS (70 for NTAPS=32), with state already IDLE.
- out_l/out_r hold their value until the next OUT.
- Tap k multiplies h[k] by x[n-k].
- Throughput constraint on the system: clk/fs ≥ 2·NTAPS+6.
- sample_valid while busy:
  - Strobe is ignored and overrun is set the next cycle.
  - The in-flight computation is unaffected.
- sample_valid in the out_valid cycle is accepted normally.
- overrun_clr clears overrun. If a set event and overrun_clr occur in the same cycle, set wins.
- dl_we is high only in WR_L, WR_R, and FLUSH.

Optional Feature:
FIR_FLUSH_ON_RESET_EN:
- When defined:
  - After reset_n deasserts, state FLUSH writes zeros to dl_addr 0..2·NTAPS-1, one per cycle, with busy=1.
  - Then IDLE.
  - A strobe during FLUSH counts as an overrun.
- When undefined: reset goes directly to IDLE and delay-line contents are retained.

Decomposition:
Package fir_seq_pkg holds:
- state enum
- DATA_W/COEF_W/ACC_W defaults
- saturation limits
- sat function

One natural sub-module, fir_mac: signed multiply, accumulate with clear/enable, shift and saturate.

Test Plan:
- Impulse response:
  - Setup: NTAPS=32, ROM h[k]=k+1, in_l=32767 once then zeros, in_r=0.
  - Response: successive out_l = 0,1,2,…,31 then 0; out_r always 0.
- Latency:
  - Stimulus: sample_valid at c0.
  - Response: busy high c1..c69; out_valid high only at c70; dl_we high only at c1,c2.
- Saturation:
  - Setup: all coef=0x7FFF.
  - Stimulus: 32 samples of 32767 → out=32767; 32 samples of -32768 → out=-32768.
  - Response: no wrap.
- Overrun:
  - Stimulus: extra strobe at c10.
  - Response: overrun=1 from c11; outputs match a single-sample model; overrun_clr → 0; clr plus simultaneous set → stays 1.
- Wrap:
  - Stimulus: 40 ramp samples (L=i, R=-i), ROM random.
  - Response: head wraps 0→31; every out_l/out_r matches the bit-accurate model.
- Reset:
  - Stimulus: reset_n low at c20.
  - Response: immediately busy=0, outputs 0, no out_valid.
  - With FIR_FLUSH_ON_RESET_EN: 64 zero writes to addresses 0..63 after release, busy high throughout.
